// File: rtl/issue_defs_pkg.sv
// Pipeline packet types exchanged between issue, execute_div and commit.
package issue_defs_pkg;

  typedef struct packed {
    logic        enable;
    logic        valid;
    logic [6:0]  rob_id;
    logic [5:0]  dest_phy;
    logic [31:0] src1_value;
    logic [31:0] src2_value;
    logic [1:0]  sub_op;
  } issue_execute_pack_t;

  typedef struct packed {
    logic       enable;
    logic       flush;
    logic [6:0] next_handle_rob_id;
    logic       has_exception;
  } commit_feedback_pack_t;

endpackage

// File: rtl/issue_div_fifo_if.sv
// Issue-to-divider queue bus: issue side pushes, execute_div side pops.
interface issue_div_fifo_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  issue_defs_pkg::issue_execute_pack_t issue_div_fifo_data_in;
  logic                                issue_div_fifo_push;
  logic                                issue_div_fifo_full;
  logic [CNT_W-1:0]                    issue_div_fifo_count;
  issue_defs_pkg::issue_execute_pack_t issue_div_fifo_data_out;
  logic                                issue_div_fifo_data_out_valid;
  logic                                issue_div_fifo_pop;

  modport master (
    output issue_div_fifo_data_in,
    output issue_div_fifo_push,
    output issue_div_fifo_pop,
    input  issue_div_fifo_full,
    input  issue_div_fifo_count,
    input  issue_div_fifo_data_out,
    input  issue_div_fifo_data_out_valid
  );

  modport slave (
    input  issue_div_fifo_data_in,
    input  issue_div_fifo_push,
    input  issue_div_fifo_pop,
    output issue_div_fifo_full,
    output issue_div_fifo_count,
    output issue_div_fifo_data_out,
    output issue_div_fifo_data_out_valid
  );

endinterface

// File: rtl/issue_div_fifo.sv
// First-word-fall-through queue feeding one divide unit; a commit flush
// empties it. All outputs derive from registered state only.
module issue_div_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  issue_div_fifo_if.slave                       bus,
  input  issue_defs_pkg::commit_feedback_pack_t commit_feedback_pack
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  issue_defs_pkg::issue_execute_pack_t r_storage [DEPTH];
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_count;

  logic             w_flush;
  logic             w_full;
  logic             w_valid;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PTR_W-1:0] w_rptr_inc;
  logic [PTR_W-1:0] w_wptr_inc;
  logic             w_unused_cfb;

  assign w_flush   = commit_feedback_pack.enable & commit_feedback_pack.flush;
  assign w_full    = (r_count == CNT_FULL);
  assign w_valid   = (r_count != '0);
  // Accept decisions use registered full/valid: no bypass in either direction.
  assign w_push_ok = bus.issue_div_fifo_push & ~w_full;
  assign w_pop_ok  = bus.issue_div_fifo_pop & w_valid;

  // DEPTH need not be a power of two, so wrap by compare.
  assign w_rptr_inc = (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_W'(1);
  assign w_wptr_inc = (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_W'(1);

  assign w_unused_cfb = ^{commit_feedback_pack.next_handle_rob_id,
                          commit_feedback_pack.has_exception};

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= w_wptr_inc;
      end
      if (w_pop_ok) begin
        r_rptr <= w_rptr_inc;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; stale entries are masked by the count.
  always_ff @(posedge clk) begin
    if (!rst && !w_flush && w_push_ok) begin
      r_storage[r_wptr] <= bus.issue_div_fifo_data_in;
    end
  end

  assign bus.issue_div_fifo_full           = w_full;
  assign bus.issue_div_fifo_count          = r_count;
  assign bus.issue_div_fifo_data_out_valid = w_valid;
  assign bus.issue_div_fifo_data_out       = w_valid ? r_storage[r_rptr] : '0;

endmodule
